// File: rtl/abs_diff_sad_approx_if.sv
// Sample/result handshake bundle for the SAD engine.
// The master drives samples and result-ready; the slave (the engine) drives in_ready and the result.
interface abs_diff_sad_approx_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 12
);
    // Valid/ready: a transfer happens on a rising clk edge where valid & ready are both 1;
    // the sender holds its payload stable while valid=1 and ready=0.
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 approx_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] sad;
    logic                 sad_approx;

    modport master (
        output in_valid, a, b, approx_en, out_ready,
        input  in_ready, out_valid, sad, sad_approx
    );

    modport slave (
        input  in_valid, a, b, approx_en, out_ready,
        output in_ready, out_valid, sad, sad_approx
    );
endinterface

// File: rtl/abs_diff_sad_approx.sv
// Two-stage SAD engine: stage 1 registers |a-b| (optionally LSB-truncated), stage 2 accumulates
// BLOCK_LEN differences and holds the finished sum until the consumer takes it.
module abs_diff_sad_approx #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int BLOCK_LEN   = 16,
    parameter int ACC_WIDTH   = WIDTH + $clog2(BLOCK_LEN)
) (
    input logic                  clk,
    input logic                  rst,
    abs_diff_sad_approx_if.slave s_bus
);
    localparam int                CNT_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLOCK_LEN - 1);
    localparam logic [WIDTH-1:0]  APX_MASK = ~((WIDTH'(1) << APPROX_BITS) - WIDTH'(1));

    logic [CNT_W-1:0]     r_in_cnt;
    logic [WIDTH-1:0]     r_s1_diff;
    logic                 r_s1_last;
    logic                 r_s1_first;
    logic                 r_s1_apx;
    logic                 r_s1_valid;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_acc_apx;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_sad;
    logic                 r_sad_approx;

    logic                 w_accept;
    logic                 w_acc_adv;
    logic                 w_in_ready;
    logic [WIDTH-1:0]     w_abs;
    logic [WIDTH-1:0]     w_diff;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_apx;

    // Stage 2 only stalls when it must publish a result into an occupied, non-draining output.
    assign w_acc_adv  = r_s1_valid & ~(r_s1_last & r_out_valid & ~s_bus.out_ready);
    assign w_in_ready = ~rst & (~r_s1_valid | w_acc_adv);
    assign w_accept   = s_bus.in_valid & w_in_ready;

    assign w_abs  = (s_bus.a >= s_bus.b) ? (s_bus.a - s_bus.b) : (s_bus.b - s_bus.a);
    assign w_diff = s_bus.approx_en ? (w_abs & APX_MASK) : w_abs;
    assign w_sum  = (r_s1_first ? '0 : r_acc) + ACC_WIDTH'(r_s1_diff);
    assign w_apx  = (r_s1_first ? 1'b0 : r_acc_apx) | r_s1_apx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_cnt     <= '0;
            r_s1_diff    <= '0;
            r_s1_last    <= 1'b0;
            r_s1_first   <= 1'b0;
            r_s1_apx     <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_acc        <= '0;
            r_acc_apx    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_sad        <= '0;
            r_sad_approx <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_diff  <= w_diff;
                r_s1_last  <= (r_in_cnt == LAST_CNT);
                r_s1_first <= (r_in_cnt == '0);
                r_s1_apx   <= s_bus.approx_en;
                r_s1_valid <= 1'b1;
                r_in_cnt   <= (r_in_cnt == LAST_CNT) ? '0 : r_in_cnt + CNT_W'(1);
            end else if (w_acc_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (r_out_valid && s_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            // A last-sample load in the same cycle as a drain keeps out_valid high.
            if (w_acc_adv) begin
                if (r_s1_last) begin
                    r_sad        <= w_sum;
                    r_sad_approx <= w_apx;
                    r_out_valid  <= 1'b1;
                end else begin
                    r_acc     <= w_sum;
                    r_acc_apx <= w_apx;
                end
            end
        end
    end

    assign s_bus.in_ready   = w_in_ready;
    assign s_bus.out_valid  = r_out_valid;
    assign s_bus.sad        = r_sad;
    assign s_bus.sad_approx = r_sad_approx;
endmodule

// File: tb/tb_abs_diff_sad_approx.sv
// Bench for abs_diff_sad_approx: a BLOCK_LEN=4 instance driven from a sample queue and scored
// against an arithmetic model, plus BLOCK_LEN=1 and BLOCK_LEN=16 instances for the extremes.
module tb_abs_diff_sad_approx;
    typedef struct {
        int a;
        int b;
        bit apx;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    abs_diff_sad_approx_if #(.WIDTH(8), .ACC_WIDTH(10)) m_if ();
    abs_diff_sad_approx_if #(.WIDTH(8), .ACC_WIDTH(8))  one_if ();
    abs_diff_sad_approx_if #(.WIDTH(8), .ACC_WIDTH(12)) big_if ();

    abs_diff_sad_approx #(.WIDTH(8), .APPROX_BITS(4), .BLOCK_LEN(4)) dut (
        .clk(clk), .rst(rst), .s_bus(m_if)
    );
    abs_diff_sad_approx #(.WIDTH(8), .APPROX_BITS(4), .BLOCK_LEN(1)) dut_one (
        .clk(clk), .rst(rst), .s_bus(one_if)
    );
    abs_diff_sad_approx #(.WIDTH(8), .APPROX_BITS(4), .BLOCK_LEN(16)) dut_big (
        .clk(clk), .rst(rst), .s_bus(big_if)
    );

    int checks = 0;
    int errors = 0;

    smp_t         src_q[$];
    logic [10:0]  exp_q[$];
    int           mdl_cnt = 0;
    int           mdl_sum = 0;
    bit           mdl_apx = 0;
    int           or_policy = 0;
    int           cycle_no = 0;
    int           acc_cyc = 0;
    int           rise_cyc = 0;
    int           n_accept = 0;
    int           n_results = 0;
    logic [9:0]   last_sad = '0;
    logic         last_apx = 1'b0;
    bit           hold_prev = 0;
    logic [9:0]   prev_sad = '0;
    logic         prev_apx = 1'b0;
    logic         prev_ov = 1'b0;

    // Reference: each block's result is the plain sum of |a-b|, rounded down to a multiple of 16
    // for samples taken in approximate mode; the flag is the OR of the samples' mode bits.
    function automatic void model_accept(int a, int b, bit apx);
        int d;
        d = (a > b) ? a - b : b - a;
        if (apx) d = d - (d % 16);
        if (mdl_cnt == 0) begin
            mdl_sum = 0;
            mdl_apx = 0;
        end
        mdl_sum += d;
        mdl_apx |= apx;
        mdl_cnt++;
        if (mdl_cnt == 4) begin
            exp_q.push_back({mdl_apx, 10'(mdl_sum)});
            mdl_cnt = 0;
        end
    endfunction

    task automatic step_m();
        logic [10:0] exp_v;
        if (src_q.size() > 0) begin
            m_if.in_valid  = 1'b1;
            m_if.a         = 8'(src_q[0].a);
            m_if.b         = 8'(src_q[0].b);
            m_if.approx_en = src_q[0].apx;
        end else begin
            m_if.in_valid  = 1'b0;
            m_if.a         = 8'($urandom_range(0, 255));
            m_if.b         = 8'($urandom_range(0, 255));
            m_if.approx_en = 1'($urandom_range(0, 1));
        end
        if (or_policy == 0) m_if.out_ready = 1'b1;
        else if (or_policy == 1) m_if.out_ready = ($urandom_range(0, 3) != 0);
        else if (or_policy == 2) m_if.out_ready = 1'b0;
        @(negedge clk);
        if (hold_prev) begin
            checks++;
            if (m_if.out_valid !== 1'b1 || m_if.sad !== prev_sad || m_if.sad_approx !== prev_apx) begin
                errors++;
                $display("FAIL hold_stable: got valid=%b sad=%0d apx=%b, required valid=1 sad=%0d apx=%b",
                         m_if.out_valid, m_if.sad, m_if.sad_approx, prev_sad, prev_apx);
            end
        end
        if (m_if.in_valid && m_if.in_ready) begin
            model_accept(src_q[0].a, src_q[0].b, src_q[0].apx);
            void'(src_q.pop_front());
            n_accept++;
            acc_cyc = cycle_no;
        end
        if (m_if.out_valid && !prev_ov) rise_cyc = cycle_no;
        if (m_if.out_valid && m_if.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got sad=%0d apx=%b, required no result", m_if.sad, m_if.sad_approx);
            end else begin
                exp_v = exp_q.pop_front();
                if ({m_if.sad_approx, m_if.sad} !== exp_v) begin
                    errors++;
                    $display("FAIL scoreboard: got sad=%0d apx=%b, required sad=%0d apx=%b",
                             m_if.sad, m_if.sad_approx, exp_v[9:0], exp_v[10]);
                end
            end
            n_results++;
            last_sad = m_if.sad;
            last_apx = m_if.sad_approx;
        end
        hold_prev = m_if.out_valid && !m_if.out_ready;
        prev_sad  = m_if.sad;
        prev_apx  = m_if.sad_approx;
        prev_ov   = m_if.out_valid;
        cycle_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name, int max_cycles);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
            step_m();
            n++;
        end
        checks++;
        if (src_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d samples / %0d results pending, required 0 / 0",
                     name, src_q.size(), exp_q.size());
        end
        repeat (2) step_m();
    endtask

    task automatic push_n(int n, int a, int b, bit apx);
        smp_t s;
        s.a = a;
        s.b = b;
        s.apx = apx;
        repeat (n) src_q.push_back(s);
    endtask

    task automatic test_reset();
        m_if.in_valid = 0; m_if.a = 0; m_if.b = 0; m_if.approx_en = 0; m_if.out_ready = 0;
        one_if.in_valid = 0; one_if.a = 0; one_if.b = 0; one_if.approx_en = 0; one_if.out_ready = 0;
        big_if.in_valid = 0; big_if.a = 0; big_if.b = 0; big_if.approx_en = 0; big_if.out_ready = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_if.in_ready !== 1'b0 || m_if.out_valid !== 1'b0 || m_if.sad !== 10'd0 || m_if.sad_approx !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b valid=%b sad=%0d apx=%b, required 0 0 0 0",
                     m_if.in_ready, m_if.out_valid, m_if.sad, m_if.sad_approx);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (m_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", m_if.in_ready);
        end
    endtask

    task automatic test_exact();
        int r0;
        r0 = n_results;
        or_policy = 0;
        push_n(4, 200, 50, 0);
        drain("exact", 50);
        checks++;
        if (n_results - r0 != 1 || last_sad !== 10'd600 || last_apx !== 1'b0) begin
            errors++;
            $display("FAIL exact_result: got n=%0d sad=%0d apx=%b, required n=1 sad=600 apx=0",
                     n_results - r0, last_sad, last_apx);
        end
        checks++;
        if (rise_cyc - acc_cyc != 2) begin
            errors++;
            $display("FAIL exact_latency: got %0d cycles, required 2", rise_cyc - acc_cyc);
        end
    endtask

    task automatic test_approx();
        int r0;
        r0 = n_results;
        or_policy = 0;
        push_n(4, 200, 50, 1);
        drain("approx_a", 50);
        checks++;
        if (last_sad !== 10'd576 || last_apx !== 1'b1) begin
            errors++;
            $display("FAIL approx_200_50: got sad=%0d apx=%b, required sad=576 apx=1", last_sad, last_apx);
        end
        push_n(4, 50, 200, 1);
        drain("approx_b", 50);
        checks++;
        if (last_sad !== 10'd576 || last_apx !== 1'b1) begin
            errors++;
            $display("FAIL approx_50_200: got sad=%0d apx=%b, required sad=576 apx=1", last_sad, last_apx);
        end
        push_n(4, 7, 3, 1);
        drain("approx_c", 50);
        checks++;
        if (last_sad !== 10'd0 || last_apx !== 1'b1 || n_results - r0 != 3) begin
            errors++;
            $display("FAIL approx_7_3: got sad=%0d apx=%b n=%0d, required sad=0 apx=1 n=3",
                     last_sad, last_apx, n_results - r0);
        end
    endtask

    task automatic test_mixed();
        or_policy = 0;
        push_n(2, 200, 50, 0);
        push_n(1, 7, 3, 1);
        push_n(1, 7, 3, 0);
        drain("mixed", 50);
        checks++;
        if (last_sad !== 10'd304 || last_apx !== 1'b1) begin
            errors++;
            $display("FAIL mixed: got sad=%0d apx=%b, required sad=304 apx=1", last_sad, last_apx);
        end
    endtask

    task automatic test_backpressure();
        int a0;
        int r0;
        a0 = n_accept;
        r0 = n_results;
        or_policy = 3;
        m_if.out_ready = 1'b0;
        push_n(12, 255, 0, 0);
        repeat (20) step_m();
        checks++;
        if (n_accept - a0 != 8 || m_if.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: got accepted=%0d in_ready=%b, required accepted=8 in_ready=0",
                     n_accept - a0, m_if.in_ready);
        end
        checks++;
        if (m_if.out_valid !== 1'b1 || m_if.sad !== 10'd1020) begin
            errors++;
            $display("FAIL bp_held: got valid=%b sad=%0d, required valid=1 sad=1020", m_if.out_valid, m_if.sad);
        end
        for (int r = 0; r < 3; r++) begin
            m_if.out_ready = 1'b1;
            step_m();
            m_if.out_ready = 1'b0;
            repeat (8) step_m();
        end
        checks++;
        if (n_results - r0 != 3 || last_sad !== 10'd1020 || src_q.size() != 0 || exp_q.size() != 0
            || n_accept - a0 != 12) begin
            errors++;
            $display("FAIL bp_results: got n=%0d sad=%0d accepted=%0d pending=%0d, required n=3 sad=1020 accepted=12 pending=0",
                     n_results - r0, last_sad, n_accept - a0, exp_q.size());
        end
        or_policy = 0;
        repeat (2) step_m();
    endtask

    task automatic test_reset_mid_block();
        or_policy = 2;
        push_n(4, 20, 0, 0);
        push_n(2, 10, 0, 0);
        repeat (10) step_m();
        rst = 1'b1;
        #2;
        checks++;
        if (m_if.in_ready !== 1'b0 || m_if.out_valid !== 1'b0 || m_if.sad !== 10'd0 || m_if.sad_approx !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rdy=%b valid=%b sad=%0d apx=%b, required 0 0 0 0",
                     m_if.in_ready, m_if.out_valid, m_if.sad, m_if.sad_approx);
        end
        src_q.delete();
        exp_q.delete();
        mdl_cnt = 0;
        hold_prev = 0;
        prev_ov = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        or_policy = 0;
        push_n(4, 1, 0, 0);
        drain("mid_reset", 50);
        checks++;
        if (last_sad !== 10'd4 || last_apx !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_result: got sad=%0d apx=%b, required sad=4 apx=0", last_sad, last_apx);
        end
    endtask

    task automatic test_random();
        int r0;
        smp_t s;
        r0 = n_results;
        or_policy = 1;
        for (int i = 0; i < 200; i++) begin
            s.a = $urandom_range(0, 255);
            s.b = ($urandom_range(0, 7) == 0) ? s.a : $urandom_range(0, 255);
            s.apx = 1'($urandom_range(0, 1));
            src_q.push_back(s);
        end
        drain("random", 3000);
        checks++;
        if (n_results - r0 != 50) begin
            errors++;
            $display("FAIL random_count: got %0d results, required 50", n_results - r0);
        end
        or_policy = 0;
    endtask

    task automatic test_block_len_one();
        int acc;
        acc = 0;
        one_if.a = 8'd0;
        one_if.b = 8'd255;
        one_if.approx_en = 1'b0;
        one_if.out_ready = 1'b1;
        one_if.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (one_if.in_ready) acc++;
            if (i >= 2) begin
                checks++;
                if (one_if.out_valid !== 1'b1 || one_if.sad !== 8'd255 || one_if.sad_approx !== 1'b0) begin
                    errors++;
                    $display("FAIL len1_result[%0d]: got valid=%b sad=%0d apx=%b, required 1 255 0",
                             i, one_if.out_valid, one_if.sad, one_if.sad_approx);
                end
            end
        end
        checks++;
        if (acc != 10) begin
            errors++;
            $display("FAIL len1_throughput: got %0d accepts, required 10", acc);
        end
        @(posedge clk);
        #1;
        one_if.in_valid = 1'b0;
    endtask

    task automatic test_block_len_16();
        int acc;
        int n;
        acc = 0;
        n = 0;
        big_if.a = 8'd255;
        big_if.b = 8'd0;
        big_if.approx_en = 1'b0;
        big_if.out_ready = 1'b1;
        while (acc < 16 && n < 40) begin
            big_if.in_valid = 1'b1;
            @(negedge clk);
            if (big_if.in_ready) acc++;
            @(posedge clk);
            #1;
            n++;
        end
        big_if.in_valid = 1'b0;
        n = 0;
        while (big_if.out_valid !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (big_if.out_valid !== 1'b1 || big_if.sad !== 12'd4080 || big_if.sad_approx !== 1'b0 || acc != 16) begin
            errors++;
            $display("FAIL len16_result: got valid=%b sad=%0d apx=%b accepted=%0d, required 1 4080 0 16",
                     big_if.out_valid, big_if.sad, big_if.sad_approx, acc);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_approx();
        test_mixed();
        test_backpressure();
        test_reset_mid_block();
        test_random();
        test_block_len_one();
        test_block_len_16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/abs_diff_sad_approx.md
# abs_diff_sad_approx

Parametrised, pipelined sum-of-absolute-differences (SAD) engine built on the approximate absolute-difference datapath. Each accepted sample pair contributes |a−b|. When approximation is enabled, the APPROX_BITS LSBs of that difference are forced to zero. The block sums BLOCK_LEN consecutive differences into one SAD result. Input and output use valid/ready handshakes with full backpressure, so the block sits between a pixel/sample stream source and a downstream motion-estimation or error-metric consumer.

## Interface

Parameters:
- WIDTH, 8, operand width in bits (≥2)
- APPROX_BITS, 4, LSBs of |a−b| zeroed in approximate mode (0..WIDTH−1)
- BLOCK_LEN, 16, samples per SAD result (≥1)
- ACC_WIDTH, WIDTH+$clog2(BLOCK_LEN), derived; result width, never overflows

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample pair present
- in_ready  out  1  block accepts sample this cycle
- a  in  WIDTH  unsigned operand
- b  in  WIDTH  unsigned operand
- approx_en  in  1  per-sample mode, sampled with a/b on acceptance
- out_valid  out  1  SAD result held
- out_ready  in  1  consumer takes result
- sad  out  ACC_WIDTH  sum of BLOCK_LEN (possibly truncated) differences
- sad_approx  out  1  1 if any sample of this block was taken with approx_en=1

## Operation

- Accept: in_valid & in_ready.
- Stage 1 (s1) register on accept:
  - s1_diff = |a−b| as WIDTH bits, using exact unsigned compare-and-subtract, no wrap.
  - If approx_en=1, s1_diff[APPROX_BITS−1:0] is set to 0.
  - s1_last = (in_cnt == BLOCK_LEN−1).
  - s1_first = (in_cnt == 0).
  - s1_apx = approx_en.
  - s1_valid = 1.
- in_cnt: increments on accept and wraps BLOCK_LEN−1 → 0.
- Advance condition: acc_adv = s1_valid & ~(s1_last & out_valid & ~out_ready).
- in_ready = ~rst & (~s1_valid | acc_adv).
- On acc_adv:
  - sum = (s1_first ? 0 : acc) + s1_diff.
  - apx = (s1_first ? 0 : acc_apx) | s1_apx.
  - If s1_last: sad←sum, sad_approx←apx, out_valid←1. acc is don't-care.
  - Otherwise: acc←sum, acc_apx←apx.
- s1_valid clears on acc_adv unless a new sample is accepted in the same cycle.
- Output:
  - out_valid clears on out_valid & out_ready, unless a new last-sample load occurs in the same cycle; in that case out_valid stays 1 with the new sad.
  - sad and sad_approx are stable while out_valid & ~out_ready.
- BLOCK_LEN=1: every sample is both first and last, and sad = s1_diff.
- APPROX_BITS=0: approx_en has no numeric effect, but still sets sad_approx.

## Timing

- Reset values:
  - in_cnt=0, s1_valid=0, acc=0, acc_apx=0.
  - out_valid=0, sad=0, sad_approx=0.
  - in_ready=0 while rst is high, and 1 in the first cycle after release.
- Reset mid-block discards the partial sum and any unconsumed result. The next accepted sample starts a new block.
- Latency: the last sample of a block is accepted at edge t; out_valid=1 after edge t+1. Nothing is combinational from input to output.
- Throughput: one sample per cycle while out_ready=1 or no block completes.
- Backpressure:
  - A stall occurs only when s1 holds a last sample and the output is occupied and not draining.
  - While stalled, in_ready=0 and s1 holds its contents.
  - No sample is lost or duplicated.
- in_valid with in_ready=0: the inputs are ignored and the source must hold them. The block does not check for source protocol violations.

## Test plan

- Exact mode, WIDTH=8, APPROX_BITS=4, BLOCK_LEN=4: four pairs (200,50), in_valid held high, out_ready=1 → one out_valid pulse, sad=600, sad_approx=0, 2 cycles after the 4th accept.
- Approx mode: same stimulus with approx_en=1 → sad=576 (4×0x90), sad_approx=1. Pairs (50,200) give an identical result. Pairs (7,3) ×4 → sad=0.
- Mixed mode: pairs (200,50),(200,50),(7,3),(7,3), with approx_en=1 only on the 3rd sample → sad=150+150+0+4=304, sad_approx=1.
- Backpressure: stream 12 pairs (255,0), exact, out_ready=0 → first result sad=1020 holds. in_ready drops once s1 holds the 8th sample. Then raise out_ready for 1 cycle per result → exactly three results of 1020, in order.
- Reset mid-block: accept 2 pairs (10,0), pulse rst, then accept 4 pairs (1,0) → sad=4. All outputs are 0 during rst.
- Extremes: BLOCK_LEN=1 with pair (0,255) → sad=255 each cycle at full throughput. WIDTH=8, BLOCK_LEN=16 with all (255,0) → sad=4080, fitting ACC_WIDTH=12 with no wrap.
